// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed display bus and
// rebuilds the eight hex digits and dot points once every digit is seen.
module ssd_scan_decoder #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  An,
  input  logic [7:0]  Cath,
  input  logic        err_clr,
  output logic [31:0] frame_digits,
  output logic [7:0]  frame_dp,
  output logic        frame_valid,
  output logic        code_err,
  output logic        anode_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t      r_state;
  logic [7:0]  r_an;
  logic [7:0]  r_cath;
  logic [7:0]  r_cnt;
  logic [7:0]  r_mask;
  logic [31:0] r_slots;
  logic [7:0]  r_dps;

  logic [3:0]  w_nlow;
  logic        w_one;
  logic        w_multi;
  logic        w_chg;
  logic [2:0]  w_idx;
  logic [4:0]  w_dec;
  logic [7:0]  w_lim;

  assign w_nlow  = 4'($countones(~An));
  assign w_one   = (w_nlow == 4'd1);
  assign w_multi = (w_nlow > 4'd1);
  assign w_chg   = (An != r_an) || (Cath != r_cath);
  assign w_lim   = 8'(SETTLE_CYC);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!r_an[i]) w_idx = 3'(i);
    end
  end

  // {valid, nibble} for the registered abcdefg pattern
  always_comb begin
    w_dec = 5'h00;
    case (r_cath[7:1])
      7'b0000001: w_dec = 5'h10;
      7'b1001111: w_dec = 5'h11;
      7'b0010010: w_dec = 5'h12;
      7'b0000110: w_dec = 5'h13;
      7'b1001100: w_dec = 5'h14;
      7'b0100100: w_dec = 5'h15;
      7'b0100000: w_dec = 5'h16;
      7'b0001111: w_dec = 5'h17;
      7'b0000000: w_dec = 5'h18;
      7'b0000100: w_dec = 5'h19;
      7'b0001000: w_dec = 5'h1A;
      7'b1100000: w_dec = 5'h1B;
      7'b0110001: w_dec = 5'h1C;
      7'b1000010: w_dec = 5'h1D;
      7'b0110000: w_dec = 5'h1E;
      7'b0111000: w_dec = 5'h1F;
      default:    w_dec = 5'h00;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_an         <= 8'hFF;
      r_cath       <= 8'hFF;
      r_cnt        <= 8'd0;
      r_mask       <= 8'h00;
      r_slots      <= 32'h0;
      r_dps        <= 8'h00;
      frame_digits <= 32'h0;
      frame_dp     <= 8'h00;
      frame_valid  <= 1'b0;
      code_err     <= 1'b0;
      anode_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (err_clr) begin
        code_err  <= 1'b0;
        anode_err <= 1'b0;
      end
      if (r_mask == 8'hFF) begin
        frame_digits <= r_slots;
        frame_dp     <= r_dps;
        frame_valid  <= 1'b1;
        r_mask       <= 8'h00;
      end
      // later assignments win, so error events override err_clr
      if (w_multi) begin
        anode_err <= 1'b1;
        r_state   <= IDLE;
        r_cnt     <= 8'd0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_one) begin
              r_state <= SETTLE;
              r_cnt   <= 8'd1;
              r_an    <= An;
              r_cath  <= Cath;
            end
          end
          SETTLE: begin
            if (w_chg) begin
              if (w_one) begin
                r_cnt  <= 8'd1;
                r_an   <= An;
                r_cath <= Cath;
              end else begin
                r_state <= IDLE;
                r_cnt   <= 8'd0;
              end
            end else if (r_cnt == w_lim) begin
              r_state <= HOLD;
              if (w_dec[4]) begin
                r_slots[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
                r_dps[w_idx]  <= ~r_cath[0];
                r_mask[w_idx] <= 1'b1;
              end else begin
                code_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          HOLD: begin
            if (w_chg) begin
              if (w_one) begin
                r_state <= SETTLE;
                r_cnt   <= 8'd1;
                r_an    <= An;
                r_cath  <= Cath;
              end else begin
                r_state <= IDLE;
                r_cnt   <= 8'd0;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule
